// File: rtl/series_datapath_arbiter.sv
// Round-robin, non-preemptive sequencer that drives a shared iterative multiply/sum
// series datapath (read, init, then mult/sum/load iterations) for NUM_REQ requesters.
module series_datapath_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2,
  parameter int ITER_W  = 4
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req,
  input  logic [ITER_W-1:0]  cfg_iters,
  input  logic               term,
  output logic               read,
  output logic               load_y,
  output logic               select_y,
  output logic               mult,
  output logic               sum,
  output logic [IDX_W-1:0]   owner,
  output logic [NUM_REQ-1:0] grant,
  output logic [NUM_REQ-1:0] done,
  output logic               busy
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    READ = 3'd1,
    INIT = 3'd2,
    MULT = 3'd3,
    SUM  = 3'd4,
    LOAD = 3'd5,
    DONE = 3'd6
  } state_t;

  localparam logic [ITER_W-1:0] ITER_ONE  = ITER_W'(1);
  localparam logic [IDX_W-1:0]  LAST_INIT = IDX_W'(NUM_REQ - 1);

  state_t              state_q, state_d;
  logic [IDX_W-1:0]    owner_q, owner_d;
  logic [IDX_W-1:0]    last_q, last_d;
  logic [ITER_W-1:0]   cnt_q, cnt_d;
  logic [ITER_W-1:0]   limit_q, limit_d;
  logic [ITER_W-1:0]   cnt_inc;
  logic [IDX_W:0]      pick;

  logic                read_q, read_d;
  logic                load_y_q, load_y_d;
  logic                select_y_q, select_y_d;
  logic                mult_q, mult_d;
  logic                sum_q, sum_d;
  logic                busy_q, busy_d;
  logic [NUM_REQ-1:0]  grant_q, grant_d;
  logic [NUM_REQ-1:0]  done_q, done_d;

  // Returns {found, index}: first set req bit scanning upward from last+1 with wrap.
  // Scanning from the farthest offset down lets the nearest candidate win.
  function automatic logic [IDX_W:0] rr_pick(input logic [NUM_REQ-1:0] r,
                                             input logic [IDX_W-1:0]   last);
    logic [IDX_W:0]   res;
    logic [IDX_W-1:0] idx;
    res = '0;
    for (int i = NUM_REQ; i >= 1; i--) begin
      idx = IDX_W'((int'(last) + i) % NUM_REQ);
      if (r[idx]) begin
        res = {1'b1, idx};
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

  function automatic logic [NUM_REQ-1:0] onehot(input logic [IDX_W-1:0] idx);
    logic [NUM_REQ-1:0] v;
    v = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  // Next-state, arbitration, iteration counter and limit latch.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    limit_d = limit_q;
    pick    = rr_pick(req, last_q);
    cnt_inc = cnt_q + ITER_ONE;
    case (state_q)
      IDLE: begin
        if (pick[IDX_W]) begin
          owner_d = pick[IDX_W-1:0];
          last_d  = pick[IDX_W-1:0];
          state_d = READ;
        end else begin
          state_d = IDLE;
        end
      end
      READ: begin
        limit_d = (cfg_iters == '0) ? ITER_ONE : cfg_iters;
        state_d = INIT;
      end
      INIT: begin
        cnt_d   = '0;
        state_d = MULT;
      end
      MULT: state_d = SUM;
      SUM:  state_d = LOAD;
      LOAD: begin
        cnt_d = cnt_inc;
        if (term || (cnt_inc == limit_q)) begin
          state_d = DONE;
        end else begin
          state_d = MULT;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Moore decode of the upcoming state so the outputs come straight from flops.
  always_comb begin
    read_d     = 1'b0;
    load_y_d   = 1'b0;
    select_y_d = 1'b0;
    mult_d     = 1'b0;
    sum_d      = 1'b0;
    done_d     = '0;
    busy_d     = (state_d != IDLE);
    grant_d    = (state_d != IDLE) ? onehot(owner_d) : '0;
    case (state_d)
      IDLE: busy_d = 1'b0;
      READ: read_d = 1'b1;
      INIT: begin
        load_y_d   = 1'b1;
        select_y_d = 1'b0;
      end
      MULT: mult_d = 1'b1;
      SUM:  sum_d  = 1'b1;
      LOAD: begin
        load_y_d   = 1'b1;
        select_y_d = 1'b1;
      end
      DONE:    done_d = onehot(owner_d);
      default: busy_d = 1'b0;
    endcase
  end

  // State, bookkeeping and output registers; reset aborts any operation in flight.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      owner_q    <= '0;
      last_q     <= LAST_INIT;
      cnt_q      <= '0;
      limit_q    <= '0;
      read_q     <= 1'b0;
      load_y_q   <= 1'b0;
      select_y_q <= 1'b0;
      mult_q     <= 1'b0;
      sum_q      <= 1'b0;
      busy_q     <= 1'b0;
      grant_q    <= '0;
      done_q     <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      last_q     <= last_d;
      cnt_q      <= cnt_d;
      limit_q    <= limit_d;
      read_q     <= read_d;
      load_y_q   <= load_y_d;
      select_y_q <= select_y_d;
      mult_q     <= mult_d;
      sum_q      <= sum_d;
      busy_q     <= busy_d;
      grant_q    <= grant_d;
      done_q     <= done_d;
    end
  end

  assign read     = read_q;
  assign load_y   = load_y_q;
  assign select_y = select_y_q;
  assign mult     = mult_q;
  assign sum      = sum_q;
  assign owner    = owner_q;
  assign grant    = grant_q;
  assign done     = done_q;
  assign busy     = busy_q;

endmodule
